// File: rtl/board_checkout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_checkout_pkg
// Description : Shared definitions for the board checkout reporter: default
//               checkout parameters, frame constants, the reporter FSM state
//               type and the frame checksum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package board_checkout_pkg;

    localparam int DEFAULT_NUM_RESULTS  = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 564;   // 65 MHz / 115200 baud

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } report_state_t;

    // Mod-256 sum of the first seven frame bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0]  idx,
                                                  input logic [7:0]  flags,
                                                  input logic [31:0] data);
        logic [7:0] sum;
        sum = SYNC_BYTE + idx;
        sum = sum + flags;
        sum = sum + data[31:24];
        sum = sum + data[23:16];
        sum = sum + data[15:8];
        sum = sum + data[7:0];
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : board_uart_tx
// Description : UART 8N1 transmitter. Accepts a byte whenever ready is high;
//               ready is also asserted on the last cycle of the stop bit so a
//               new byte can follow with no idle gap.
// Ports       : clk, rst_n (async, active-low)
//               data[7:0], valid  - byte to send and its strobe
//               ready             - transmitter can take a byte this cycle
//               tx                - serial line, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_STOP_IDX = 4'd9;  // 0 = start, 1..8 = data

    logic               r_active;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit;
    logic [8:0]         r_shift;   // remaining data bits with the stop bit on top
    logic               r_tx;
    logic               w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_LAST);
    assign ready     = !r_active || ((r_bit == c_STOP_IDX) && w_bit_end);
    assign tx        = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= '1;
            r_tx     <= 1'b1;
        end else if (valid && ready) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= {1'b1, data};
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bit == c_STOP_IDX) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_checkout_reporter.sv
`default_nettype none
// ============================================================================
// Module      : board_checkout_reporter
// Description : Latches 32-bit checkout results per channel and, on each
//               report tick, sends one 8-byte frame per channel back to back
//               over UART 8N1:  A5, index, flags, data[31:0] MSB first, sum.
// Ports       : clk, rst_n (async, active-low)
//               report_tick       - one-cycle sweep request
//               result_valid[N]   - per-channel latch strobe
//               result_data[32*N] - channel i at [32*i +: 32]
//               tx                - UART line
//               busy              - sweep in progress
//               overrun           - sticky: tick seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module board_checkout_reporter
    import board_checkout_pkg::*;
#(
    parameter int NUM_RESULTS  = DEFAULT_NUM_RESULTS,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      report_tick,
    input  logic [NUM_RESULTS-1:0]    result_valid,
    input  logic [32*NUM_RESULTS-1:0] result_data,
    output logic                      tx,
    output logic                      busy,
    output logic                      overrun
);

    localparam logic [7:0] c_LAST_CH   = 8'(NUM_RESULTS - 1);
    localparam logic [3:0] c_FRAME_END = 4'(FRAME_BYTES);

    report_state_t r_state, w_state_next;

    logic [31:0]            r_latch [NUM_RESULTS];
    logic [NUM_RESULTS-1:0] r_fresh;
    logic [7:0]             r_ptr;
    logic [3:0]             r_byte_idx;   // bytes of the current frame already handed to the UART
    logic                   r_overrun;

    logic [7:0]  r_snap_idx;
    logic [7:0]  r_snap_flags;
    logic [31:0] r_snap_data;
    logic [7:0]  r_snap_chk;

    logic        w_snap_take;
    logic [7:0]  w_snap_sel;
    logic [31:0] w_sel_data;
    logic        w_sel_fresh;
    logic        w_uart_valid;
    logic        w_uart_ready;
    logic [7:0]  w_uart_data;
    logic [7:0]  w_frame_byte;

    assign busy    = (r_state != ST_IDLE);
    assign overrun = r_overrun;

    // Result bank. A strobe wins over the snapshot clear, so a collision
    // leaves fresh set while the snapshot still sees the pre-strobe values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RESULTS; i++) r_latch[i] <= '0;
            r_fresh <= '0;
        end else begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                if (result_valid[i]) begin
                    r_latch[i] <= result_data[32*i +: 32];
                    r_fresh[i] <= 1'b1;
                end else if (w_snap_take && (w_snap_sel == 8'(i))) begin
                    r_fresh[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_fresh = 1'b0;
        for (int i = 0; i < NUM_RESULTS; i++) begin
            if (w_snap_sel == 8'(i)) begin
                w_sel_data  = r_latch[i];
                w_sel_fresh = r_fresh[i];
            end
        end
    end

    // Snapshot of the frame in flight; later strobes only touch the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_idx   <= '0;
            r_snap_flags <= '0;
            r_snap_data  <= '0;
            r_snap_chk   <= '0;
        end else if (w_snap_take) begin
            r_snap_idx   <= w_snap_sel;
            r_snap_flags <= {7'd0, w_sel_fresh};
            r_snap_data  <= w_sel_data;
            r_snap_chk   <= frame_checksum(w_snap_sel, {7'd0, w_sel_fresh}, w_sel_data);
        end
    end

    always_comb begin
        case (r_byte_idx)
            4'd1:    w_frame_byte = r_snap_idx;
            4'd2:    w_frame_byte = r_snap_flags;
            4'd3:    w_frame_byte = r_snap_data[31:24];
            4'd4:    w_frame_byte = r_snap_data[23:16];
            4'd5:    w_frame_byte = r_snap_data[15:8];
            4'd6:    w_frame_byte = r_snap_data[7:0];
            4'd7:    w_frame_byte = r_snap_chk;
            default: w_frame_byte = SYNC_BYTE;
        endcase
    end

    // The sync byte of every frame is issued in the same cycle as that
    // frame's snapshot, which keeps the line gap-free between frames.
    always_comb begin
        w_state_next = r_state;
        w_uart_valid = 1'b0;
        w_uart_data  = SYNC_BYTE;
        w_snap_take  = 1'b0;
        w_snap_sel   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (report_tick) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_uart_valid = 1'b1;
                w_snap_take  = 1'b1;
                w_snap_sel   = 8'd0;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_uart_ready) begin
                    if (r_byte_idx < c_FRAME_END) begin
                        w_uart_valid = 1'b1;
                        w_uart_data  = w_frame_byte;
                    end else if (r_ptr < c_LAST_CH) begin
                        w_uart_valid = 1'b1;
                        w_snap_take  = 1'b1;
                        w_snap_sel   = r_ptr + 8'd1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_byte_idx <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (report_tick && busy) r_overrun <= 1'b1;
            if ((r_state == ST_IDLE) && report_tick) r_ptr <= '0;
            if (r_state == ST_LOAD) begin
                r_byte_idx <= 4'd1;
            end else if ((r_state == ST_SEND) && w_uart_valid) begin
                if (w_snap_take) begin
                    r_ptr      <= w_snap_sel;
                    r_byte_idx <= 4'd1;
                end else begin
                    r_byte_idx <= r_byte_idx + 4'd1;
                end
            end
        end
    end

    board_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (w_uart_data),
        .valid (w_uart_valid),
        .ready (w_uart_ready),
        .tx    (tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_board_checkout_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_checkout_reporter
// Description : Self-checking bench for board_checkout_reporter with four
//               channels and four clocks per UART bit. Expected frames come
//               from a behavioural bank model and are queued at each tick; a
//               UART receiver decodes the line and compares byte by byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_checkout_reporter;

    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int SWEEP_BUSY = 1 + 80 * CPB * N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           report_tick = 1'b0;
    logic [N-1:0]   result_valid = '0;
    logic [32*N-1:0] result_data = '0;
    logic           tx;
    logic           busy;
    logic           overrun;

    always #5 clk = ~clk;

    board_checkout_reporter #(
        .NUM_RESULTS  (N),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .report_tick  (report_tick),
        .result_valid (result_valid),
        .result_data  (result_data),
        .tx           (tx),
        .busy         (busy),
        .overrun      (overrun)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_bytes [64];
    int          rx_n = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_data  [N];
    logic        m_fresh [N];

    typedef struct {
        logic        do_strobe;
        int          ch;
        logic [31:0] data;
        int          chk_ch;
        logic [7:0]  exp_flags;
        logic [7:0]  exp_chk;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Queue the frames the model says a sweep started now should produce.
    task automatic push_sweep();
        logic [7:0] b [8];
        logic [7:0] s;
        for (int c = 0; c < N; c++) begin
            b[0] = 8'hA5;
            b[1] = 8'(c);
            b[2] = {7'd0, m_fresh[c]};
            b[3] = m_data[c][31:24];
            b[4] = m_data[c][23:16];
            b[5] = m_data[c][15:8];
            b[6] = m_data[c][7:0];
            s = 8'd0;
            for (int k = 0; k < 7; k++) s = s + b[k];
            b[7] = s;
            for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
            m_fresh[c] = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            m_data[c]  = '0;
            m_fresh[c] = 1'b0;
        end
    endtask

    task automatic strobe(input int ch, input logic [31:0] d);
        @(negedge clk);
        result_valid[ch] = 1'b1;
        result_data[ch*32 +: 32] = d;
        m_data[ch]  = d;
        m_fresh[ch] = 1'b1;
        @(negedge clk);
        result_valid = '0;
    endtask

    // One sweep. tick_cyc/strobe_cyc are busy-cycle numbers at which an extra
    // tick / a strobe is driven (-1 none; strobe_cyc 0 = with the start tick).
    task automatic run_sweep(input int tick_cyc, input int strobe_cyc,
                             input int s_ch, input logic [31:0] s_data);
        int cycles;
        @(negedge clk);
        rx_n = 0;
        if (strobe_cyc == 0) begin
            result_valid[s_ch] = 1'b1;
            result_data[s_ch*32 +: 32] = s_data;
            m_data[s_ch]  = s_data;
            m_fresh[s_ch] = 1'b1;
        end
        push_sweep();
        report_tick = 1'b1;
        @(negedge clk);
        report_tick  = 1'b0;
        result_valid = '0;
        check(busy == 1'b1, "start_busy", 32'(busy), 32'd1);
        check(tx == 1'b1, "start_tx_idle", 32'(tx), 32'd1);
        cycles = 1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (cycles == 2) check(tx == 1'b0, "start_bit", 32'(tx), 32'd0);
            report_tick = (cycles == tick_cyc);
            if (cycles == strobe_cyc) begin
                result_valid[s_ch] = 1'b1;
                result_data[s_ch*32 +: 32] = s_data;
            end else begin
                result_valid = '0;
            end
        end
        report_tick  = 1'b0;
        result_valid = '0;
        if (strobe_cyc > 0) begin
            m_data[s_ch]  = s_data;
            m_fresh[s_ch] = 1'b1;
        end
        check(cycles == SWEEP_BUSY, "busy_len", 32'(cycles), 32'(SWEEP_BUSY));
        check(exp_q.size() == 0, "frames_drained", 32'(exp_q.size()), 32'd0);
        check(tx == 1'b1, "end_tx_idle", 32'(tx), 32'd1);
    endtask

    // UART receiver: samples once per clock, requires every bit to hold for
    // exactly CPB samples, then scores the decoded byte against the queue.
    initial begin : p_monitor
        logic       smp [BYTE_CYC];
        logic [7:0] rx_byte;
        bit         ok;
        int         cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                cnt = 0;
            end else if (cnt == 0) begin
                if (tx == 1'b0) begin
                    smp[0] = tx;
                    cnt = 1;
                end
            end else begin
                smp[cnt] = tx;
                cnt++;
                if (cnt == BYTE_CYC) begin
                    cnt = 0;
                    ok = (smp[0] == 1'b0) && (smp[9*CPB] == 1'b1);
                    for (int b = 0; b < 10; b++)
                        for (int j = 1; j < CPB; j++)
                            if (smp[b*CPB + j] != smp[b*CPB]) ok = 1'b0;
                    for (int j = 0; j < 8; j++) rx_byte[j] = smp[(j+1)*CPB];
                    check(ok, "uart_framing", 32'(rx_byte), 32'(rx_byte));
                    if (rx_n < 64) rx_bytes[rx_n] = rx_byte;
                    rx_n++;
                    if (exp_q.size() > 0) begin
                        check(rx_byte == exp_q[0], "frame_byte", 32'(rx_byte), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end else begin
                        check(1'b0, "unexpected_byte", 32'(rx_byte), 32'hFFFF_FFFF);
                    end
                end
            end
        end
    end

    initial begin : p_main
        bit quiet;
        vecs[0] = '{1'b0, 0, 32'h0000_0000, 0, 8'h00, 8'hA5};
        vecs[1] = '{1'b0, 0, 32'h0000_0000, 3, 8'h00, 8'hA8};
        vecs[2] = '{1'b1, 1, 32'h1234_5678, 1, 8'h01, 8'hBB};
        vecs[3] = '{1'b0, 0, 32'h0000_0000, 1, 8'h00, 8'hBA};
        vecs[4] = '{1'b1, 3, 32'hFFFF_FFFF, 3, 8'h01, 8'hA5};
        vecs[5] = '{1'b1, 2, 32'h0000_00FF, 2, 8'h01, 8'hA7};

        model_clear();
        repeat (3) @(negedge clk);
        check(tx == 1'b1, "reset_tx", 32'(tx), 32'd1);
        check(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);
        check(overrun == 1'b0, "reset_overrun", 32'(overrun), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven sweeps
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_strobe) strobe(vecs[i].ch, vecs[i].data);
            run_sweep(-1, -1, 0, 32'h0);
            check(rx_bytes[vecs[i].chk_ch*8 + 2] == vecs[i].exp_flags, "vec_flags",
                  32'(rx_bytes[vecs[i].chk_ch*8 + 2]), 32'(vecs[i].exp_flags));
            check(rx_bytes[vecs[i].chk_ch*8 + 7] == vecs[i].exp_chk, "vec_checksum",
                  32'(rx_bytes[vecs[i].chk_ch*8 + 7]), 32'(vecs[i].exp_chk));
        end

        // Strobe on the channel-2 snapshot cycle: old data now, new data next sweep
        run_sweep(-1, 1 + 2*80*CPB, 2, 32'hDEAD_BEEF);
        check(rx_bytes[18] == 8'h00, "collide_flags", 32'(rx_bytes[18]), 32'h00);
        check(rx_bytes[22] == 8'hFF, "collide_old_data", 32'(rx_bytes[22]), 32'hFF);
        run_sweep(-1, -1, 0, 32'h0);
        check(rx_bytes[18] == 8'h01, "next_flags", 32'(rx_bytes[18]), 32'h01);
        check(rx_bytes[19] == 8'hDE, "next_data_msb", 32'(rx_bytes[19]), 32'hDE);
        check(rx_bytes[23] == 8'hE0, "next_checksum", 32'(rx_bytes[23]), 32'hE0);

        // Tick mid-sweep: overrun, no extra sweep, unchanged duration
        check(overrun == 1'b0, "overrun_before", 32'(overrun), 32'd0);
        run_sweep(100, -1, 0, 32'h0);
        check(overrun == 1'b1, "overrun_set", 32'(overrun), 32'd1);
        repeat (20) @(negedge clk);
        check(busy == 1'b0, "no_queued_sweep", 32'(busy), 32'd0);
        check(overrun == 1'b1, "overrun_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset during a data bit of channel 1's sync byte
        @(negedge clk);
        push_sweep();
        report_tick = 1'b1;
        @(negedge clk);
        report_tick = 1'b0;
        repeat (80*CPB + 2*CPB + 2) @(negedge clk);
        check(tx == 1'b0, "pre_reset_tx", 32'(tx), 32'd0);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check(tx == 1'b1, "async_rst_tx", 32'(tx), 32'd1);
        check(busy == 1'b0, "async_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check(overrun == 1'b0, "rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        model_clear();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        quiet  = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check(quiet, "quiet_after_reset", 32'(quiet), 32'd1);
        run_sweep(-1, -1, 0, 32'h0);
        check(rx_bytes[22] == 8'h00, "latch_cleared", 32'(rx_bytes[22]), 32'h00);

        // Tick sampled on the edge where busy falls
        run_sweep(SWEEP_BUSY, -1, 0, 32'h0);
        check(overrun == 1'b1, "fall_edge_overrun", 32'(overrun), 32'd1);
        repeat (20) @(negedge clk);
        check(busy == 1'b0, "fall_edge_no_sweep", 32'(busy), 32'd0);

        // Tick together with a channel-0 strobe
        run_sweep(-1, 0, 0, 32'hCAFE_F00D);
        check(rx_bytes[2] == 8'h01, "tick_strobe_flags", 32'(rx_bytes[2]), 32'h01);
        check(rx_bytes[3] == 8'hCA, "tick_strobe_data", 32'(rx_bytes[3]), 32'hCA);
        check(rx_bytes[7] == 8'h6B, "tick_strobe_chk", 32'(rx_bytes[7]), 32'h6B);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
